// File: rtl/enoc_switch_control_wormhole.sv
// Credit-based wormhole crossbar controller: per-output round-robin head arbitration,
// lock from head to tail flit, and downstream credit tracking with a sticky overflow flag.
module enoc_switch_control_wormhole #(
    parameter int N       = 5,
    parameter int M       = 5,
    parameter int CREDITS = 4,
    localparam int CW     = $clog2(CREDITS + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
    input  logic [0:N-1][0:M-1]  i_output_req,
    input  logic [0:N-1]         i_tail,
    input  logic [0:M-1]         i_credit_return,
    output logic [0:M-1][0:N-1]  o_output_grant,
    output logic [0:N-1]         o_input_grant,
    output logic [0:M-1][CW-1:0] o_credit_count,
    output logic [0:M-1]         o_locked,
    output logic                 o_credit_err
);
    localparam int            PW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    logic [0:M-1][CW-1:0] credit_q, credit_d;
    logic [0:M-1]         locked_q, locked_d;
    logic [0:M-1][PW-1:0] owner_q, owner_d;
    logic [0:M-1][PW-1:0] ptr_q, ptr_d;
    logic                 err_q, err_d;

    logic [0:N-1][0:M-1]  req_eff;
    logic [0:N-1]         req_seen;
    logic [0:M-1][0:N-1]  grant;
    logic [0:M-1]         granted;
    logic [0:M-1]         rr_found;
    int                   rr_idx;

    // An illegal multi-hot request keeps only its lowest output, so no input is granted twice.
    always_comb begin
        req_eff  = '0;
        req_seen = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                req_eff[i][j] = i_output_req[i][j] & ~req_seen[i];
                req_seen[i]   = req_seen[i] | i_output_req[i][j];
            end
        end
    end

    always_comb begin
        grant    = '0;
        rr_found = '0;
        rr_idx   = 0;
        for (int j = 0; j < M; j++) begin
            if (ce && reset_n && (credit_q[j] != '0)) begin
                if (locked_q[j]) begin
                    grant[j][owner_q[j]] = req_eff[owner_q[j]][j];
                end else begin
                    for (int off = 0; off < N; off++) begin
                        rr_idx = int'(ptr_q[j]) + off;
                        if (rr_idx >= N) rr_idx = rr_idx - N;
                        if (!rr_found[j] && req_eff[rr_idx][j]) begin
                            grant[j][rr_idx] = 1'b1;
                            rr_found[j]      = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        o_input_grant = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                o_input_grant[i] = o_input_grant[i] | grant[j][i];
            end
        end
    end

    always_comb begin
        credit_d = credit_q;
        locked_d = locked_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        granted  = '0;
        for (int j = 0; j < M; j++) begin
            granted[j] = |grant[j];
        end
        if (ce) begin
            for (int j = 0; j < M; j++) begin
                for (int i = 0; i < N; i++) begin
                    if (grant[j][i]) begin
                        locked_d[j] = ~i_tail[i];
                        if (!i_tail[i]) owner_d[j] = PW'(i);
                        // Pointer only advances on head flits so a worm never skews fairness.
                        if (!locked_q[j]) ptr_d[j] = (i == N - 1) ? '0 : PW'(i + 1);
                    end
                end
                if (granted[j] && !i_credit_return[j]) begin
                    credit_d[j] = credit_q[j] - CW'(1);
                end else if (!granted[j] && i_credit_return[j]) begin
                    if (credit_q[j] == CREDIT_MAX) err_d = 1'b1;
                    else credit_d[j] = credit_q[j] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            credit_q <= {M{CREDIT_MAX}};
            locked_q <= '0;
            owner_q  <= '0;
            ptr_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            locked_q <= locked_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            err_q    <= err_d;
        end
    end

    assign o_output_grant = grant;
    assign o_credit_count = credit_q;
    assign o_locked       = locked_q;
    assign o_credit_err   = err_q;

endmodule

// File: tb/tb_enoc_switch_control_wormhole.sv
// Scoreboard bench for the wormhole switch controller: expectations are queued with each
// cycle's stimulus and drained against the DUT outputs on the falling edge.
module tb_enoc_switch_control_wormhole;
    localparam int N       = 5;
    localparam int M       = 5;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    localparam int K_GRANT  = 0;
    localparam int K_COUNT  = 1;
    localparam int K_LOCKED = 2;
    localparam int K_ERR    = 3;
    localparam int K_IGRANT = 4;

    logic                 clk;
    logic                 reset_n;
    logic                 ce;
    logic [0:N-1][0:M-1]  i_output_req;
    logic [0:N-1]         i_tail;
    logic [0:M-1]         i_credit_return;
    logic [0:M-1][0:N-1]  o_output_grant;
    logic [0:N-1]         o_input_grant;
    logic [0:M-1][CW-1:0] o_credit_count;
    logic [0:M-1]         o_locked;
    logic                 o_credit_err;

    typedef struct {
        string tag;
        int    kind;
        int    idx;
        int    exp;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    int rr_exp[4]   = '{0, 2, 4, 0};
    int wh_grant[4] = '{3, 3, 3, 1};
    int wh_lock[4]  = '{0, 1, 1, 0};
    int wh_tail[4]  = '{0, 0, 1, 1};
    int ex_count[8] = '{4, 3, 2, 1, 0, 0, 1, 0};
    int ex_grant[8] = '{0, 0, 0, 0, -1, -1, 0, -1};

    enoc_switch_control_wormhole #(.N(N), .M(M), .CREDITS(CREDITS)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ce              (ce),
        .i_output_req    (i_output_req),
        .i_tail          (i_tail),
        .i_credit_return (i_credit_return),
        .o_output_grant  (o_output_grant),
        .o_input_grant   (o_input_grant),
        .o_credit_count  (o_credit_count),
        .o_locked        (o_locked),
        .o_credit_err    (o_credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < N; i++) begin
                assert ($onehot0(i_output_req[i]))
                    else $error("illegal multi-hot request on input %0d", i);
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [0:N-1] v);
        int r   = -1;
        int cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i] === 1'b1) begin
                if (r < 0) r = i;
                cnt++;
            end else if (v[i] !== 1'b0) begin
                cnt = 99;
            end
        end
        return (cnt > 1) ? -2 : r;
    endfunction

    function automatic int observe(input int kind, input int idx);
        case (kind)
            K_GRANT:  return onehot_idx(o_output_grant[idx]);
            K_COUNT:  return int'(o_credit_count[idx]);
            K_LOCKED: return int'(o_locked[idx]);
            K_ERR:    return int'(o_credit_err);
            default:  return onehot_idx(o_input_grant);
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input int idx, input int e);
        exp_t x;
        x.tag  = tag;
        x.kind = kind;
        x.idx  = idx;
        x.exp  = e;
        sb_q.push_back(x);
    endtask

    task automatic set_req(input int i, input int j);
        i_output_req[i] = '0;
        if (j >= 0) i_output_req[i][j] = 1'b1;
    endtask

    task automatic clr_inputs();
        i_output_req    = '0;
        i_tail          = '0;
        i_credit_return = '0;
        ce              = 1'b1;
    endtask

    task automatic cycle(input string name);
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("%s.%s", name, e.tag), observe(e.kind, e.idx), e.exp);
        end
        $display("cycle %s: out_grant=%b in_grant=%b locked=%b counts=%h err=%b",
                 name, o_output_grant, o_input_grant, o_locked, o_credit_count, o_credit_err);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clr_inputs();
        set_req(0, 0);
        set_req(1, 1);
        for (int k = 0; k < 3; k++) begin
            push("g0", K_GRANT, 0, -1);
            push("g1", K_GRANT, 1, -1);
            push("ig", K_IGRANT, 0, -1);
            push("cnt0", K_COUNT, 0, CREDITS);
            push("lk0", K_LOCKED, 0, 0);
            cycle($sformatf("reset%0d", k));
        end

        clr_inputs();
        reset_n = 1'b1;
        for (int j = 0; j < M; j++) begin
            push($sformatf("cnt%0d", j), K_COUNT, j, CREDITS);
            push($sformatf("lk%0d", j), K_LOCKED, j, 0);
        end
        push("err", K_ERR, 0, 0);
        push("ig", K_IGRANT, 0, -1);
        cycle("idle");

        // round-robin among single-flit packets, credits returned every cycle
        for (int k = 0; k < 4; k++) begin
            clr_inputs();
            set_req(0, 1);
            set_req(2, 1);
            set_req(4, 1);
            i_tail             = '1;
            i_credit_return[1] = 1'b1;
            push("g1", K_GRANT, 1, rr_exp[k]);
            push("ig", K_IGRANT, 0, rr_exp[k]);
            push("cnt1", K_COUNT, 1, CREDITS);
            push("lk1", K_LOCKED, 1, 0);
            cycle($sformatf("rr%0d", k));
        end
        clr_inputs();
        push("err", K_ERR, 0, 0);
        push("cnt1", K_COUNT, 1, CREDITS);
        cycle("rr_end");

        // 3-flit worm from input 3 on output 0; input 1 contends from the second flit
        for (int k = 0; k < 4; k++) begin
            clr_inputs();
            if (k < 3) set_req(3, 0);
            if (k >= 1) set_req(1, 0);
            i_tail[3]          = (wh_tail[k] != 0);
            i_tail[1]          = 1'b1;
            i_credit_return[0] = 1'b1;
            push("g0", K_GRANT, 0, wh_grant[k]);
            push("lk0", K_LOCKED, 0, wh_lock[k]);
            push("cnt0", K_COUNT, 0, CREDITS);
            cycle($sformatf("worm%0d", k));
        end
        clr_inputs();
        push("lk0", K_LOCKED, 0, 0);
        cycle("worm_end");

        // credit exhaustion on output 2, single return pulse on step 5
        for (int k = 0; k < 8; k++) begin
            clr_inputs();
            set_req(0, 2);
            i_tail[0]          = 1'b1;
            i_credit_return[2] = (k == 5);
            push("cnt2", K_COUNT, 2, ex_count[k]);
            push("g2", K_GRANT, 2, ex_grant[k]);
            cycle($sformatf("exh%0d", k));
        end

        // grant+return at count 1, then refill and overflow
        clr_inputs();
        i_credit_return[2] = 1'b1;
        push("cnt2", K_COUNT, 2, 0);
        push("g2", K_GRANT, 2, -1);
        cycle("ret_at0");
        clr_inputs();
        set_req(0, 2);
        i_tail[0]          = 1'b1;
        i_credit_return[2] = 1'b1;
        push("cnt2", K_COUNT, 2, 1);
        push("g2", K_GRANT, 2, 0);
        cycle("gr_ret_at1");
        for (int k = 1; k <= 4; k++) begin
            clr_inputs();
            i_credit_return[2] = 1'b1;
            push("cnt2", K_COUNT, 2, k);
            push("err", K_ERR, 0, 0);
            cycle($sformatf("refill%0d", k));
        end
        clr_inputs();
        push("cnt2", K_COUNT, 2, CREDITS);
        push("err", K_ERR, 0, 1);
        cycle("overflow");
        push("err", K_ERR, 0, 1);
        cycle("err_sticky");

        // ce gating mid-packet, then an owner bubble while input 4 contends
        clr_inputs();
        set_req(2, 3);
        push("g3", K_GRANT, 3, 2);
        push("cnt3", K_COUNT, 3, CREDITS);
        push("lk3", K_LOCKED, 3, 0);
        cycle("ce_head");
        for (int k = 0; k < 2; k++) begin
            clr_inputs();
            ce = 1'b0;
            set_req(2, 3);
            i_credit_return[3] = 1'b1;
            push("g3", K_GRANT, 3, -1);
            push("ig", K_IGRANT, 0, -1);
            push("cnt3", K_COUNT, 3, 3);
            push("lk3", K_LOCKED, 3, 1);
            cycle($sformatf("ce_off%0d", k));
        end
        clr_inputs();
        set_req(4, 3);
        i_tail[4] = 1'b1;
        push("g3", K_GRANT, 3, -1);
        push("lk3", K_LOCKED, 3, 1);
        push("cnt3", K_COUNT, 3, 3);
        cycle("bubble");
        clr_inputs();
        set_req(2, 3);
        set_req(4, 3);
        i_tail[2] = 1'b1;
        i_tail[4] = 1'b1;
        push("g3", K_GRANT, 3, 2);
        push("lk3", K_LOCKED, 3, 1);
        push("cnt3", K_COUNT, 3, 3);
        cycle("owner_tail");
        clr_inputs();
        set_req(4, 3);
        i_tail[4] = 1'b1;
        push("g3", K_GRANT, 3, 4);
        push("lk3", K_LOCKED, 3, 0);
        push("cnt3", K_COUNT, 3, 2);
        cycle("next_head");
        clr_inputs();
        push("cnt3", K_COUNT, 3, 1);
        push("err", K_ERR, 0, 1);
        cycle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enoc_switch_control_wormhole.md
Name: enoc_switch_control_wormhole

Overview:
Crossbar switch controller for ENoC routers. It replaces valid/enable flow control with credit-based flow control, and packet-level flit arbitration with wormhole locking. Each output port holds a credit counter that tracks free slots in the downstream input buffer. An output stays locked to one input from the head flit to the tail flit, and new packets are arbitrated round-robin. It sits between the router input FIFOs and the crossbar select logic, and drives the crossbar selects and the FIFO read enables.

Parameters:
N, 5, number of input ports.
M, 5, number of output ports.
CREDITS, 4, downstream buffer depth per output; initial and maximum credit count (must be >= 1).
CW, $clog2(CREDITS+1), credit counter width (derived, not overridden).

Ports:
clk  input  1  clock; all state on rising edge.
reset_n  input  1  asynchronous active-low reset.
ce  input  1  clock enable; when low, state frozen and all grants forced 0.
i_output_req  input  [0:N-1][0:M-1]  per input, one-hot (or zero) output request for the flit at the FIFO head.
i_tail  input  [0:N-1]  flit at the head of input i is a tail flit (single-flit packets assert head and tail together).
i_credit_return  input  [0:M-1]  one-cycle pulse: downstream freed one slot for output j.
o_output_grant  output  [0:M-1][0:N-1]  per output, one-hot grant to an input (crossbar select).
o_input_grant  output  [0:N-1]  OR of all o_output_grant columns; FIFO read enable.
o_credit_count  output  [0:M-1][CW-1:0]  current credits per output.
o_locked  output  [0:M-1]  output j is mid-packet (locked to an owner).
o_credit_err  output  1  sticky: a credit return arrived with the count already at CREDITS.

Behaviour:
- Reset (async, reset_n low):
  - credit counts = CREDITS; all locks cleared; owners = 0; round-robin pointers = 0; o_credit_err = 0.
  - o_output_grant and o_input_grant = 0 while reset_n is low.
- Grant path is combinational from inputs and registered state, so grant appears in the same cycle as the request (0-cycle latency).
- Output j is eligible when ce = 1, reset_n = 1 and credit_count[j] > 0. A same-cycle credit return does not bypass into eligibility.
- Output j unlocked (IDLE):
  - Request set for j = {i : i_output_req[i][j]}.
  - Round-robin priority starts at ptr[j], searching ascending with wrap.
  - The first requester is granted.
- Output j locked (LOCKED, owner k):
  - Only input k can be granted, when i_output_req[k][j] = 1 and credits > 0.
  - Other requesters are masked.
  - If the owner does not request (bubble), the output idles and the lock is held.
- State update (only on rising edge with ce = 1), for each output j granted to input w:
  - credit_count[j] decrements by 1.
  - If i_tail[w] = 0: lock j, owner = w. If i_tail[w] = 1: lock cleared (single-flit packet never locks).
  - ptr[j] = (w+1) mod N, updated only on grants made from IDLE (head flits); unchanged while locked.
- Credit arithmetic per output per ce cycle: next = count - grant_j + credit_return_j.
  - Grant and return in the same cycle: count unchanged.
  - Return with count == CREDITS and no grant: count saturates at CREDITS and o_credit_err sets (sticky until reset).
  - Underflow is impossible because a grant requires count > 0.
- ce low: credit returns are ignored, because downstream shares the same ce. No pointer, lock or counter changes.
- Multi-hot i_output_req is illegal. The bench flags it with an assertion; the RTL's response is undefined but must not grant one input to two outputs (resolve to the lowest set bit).
- Reset mid-packet: locks drop immediately and credits refill. Upstream and downstream reset together.
- o_input_grant[i] = OR over j of o_output_grant[j][i]. At most one bit per row and per column is set.

Test Plan:
- Reset then idle: after reset, all o_credit_count = 4, o_locked = 0, grants 0; hold reset_n low for 3 cycles with requests active -> grants remain 0.
- Round-robin heads: inputs 0, 2 and 4 request output 1 with single-flit packets (tail = 1) every cycle, returns matched each cycle -> grant order 0, 2, 4, 0; ptr[1] = 1, 3, 0, 1.
- Wormhole lock: input 3 sends a 3-flit packet to output 0 (tail = 0, 0, 1) while input 1 also requests output 0 -> grants 3, 3, 3; o_locked[0] = 1 for 2 cycles; input 1 granted on the 4th cycle.
- Credit exhaustion: CREDITS = 4, no returns, input 0 streams to output 2 -> 4 grants, count reaches 0 and grants stop; one return pulse -> exactly one more grant on the next cycle.
- Simultaneous grant and return at count 1 -> count stays 1; return at count 4 with no grant -> count stays 4 and o_credit_err = 1 (sticky).
- ce gating plus bubble: mid-packet, ce low for 2 cycles -> grants 0 and counts frozen; then the owner drops its request for 1 cycle while another input requests -> no grant, lock held.
